// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: stalls the core while one aligned load/store runs on a req/ack memory bus,
// flagging misaligned accesses and bus timeouts.
module data_mem_ctrl #(
  parameter int MIPS_SIZE = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 MemRead,
  input  logic                 MemWrite,
  input  logic [MIPS_SIZE-1:0] ALUResult,
  input  logic [MIPS_SIZE-1:0] WriteData,
  output logic [MIPS_SIZE-1:0] ReadData,
  output logic                 Stall,
  output logic                 Addr_Err,
  output logic                 Bus_Err,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [MIPS_SIZE-1:0] mem_addr,
  output logic [MIPS_SIZE-1:0] mem_wdata,
  input  logic [MIPS_SIZE-1:0] mem_rdata,
  input  logic                 mem_ack
);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state, next;
  logic [CW-1:0] cnt;
  logic we_q, start, timeout;
  always_ff @(posedge CLK or negedge RST)
    if (!RST) state <= IDLE;
    else state <= next;
  // Request-side outputs are gated by RST so nothing leaks out while reset is held.
  always_comb begin
    start = RST && state == IDLE && (MemRead || MemWrite) && ALUResult[1:0] == 2'b00;
    timeout = state == WAIT && !mem_ack && cnt == CW'(TIMEOUT - 1);
    next = start ? WAIT : (state == WAIT && (mem_ack || timeout)) ? DONE : state == DONE ? IDLE : state;
    Stall = start || state == WAIT;
    Addr_Err = RST && state == IDLE && (MemRead || MemWrite) && ALUResult[1:0] != 2'b00;
    mem_req = state == WAIT;
    mem_we = mem_req && we_q;
  end
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      cnt <= '0;
      we_q <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      ReadData <= '0;
      Bus_Err <= 1'b0;
    end else begin
      Bus_Err <= timeout;
      if (start) begin
        cnt <= '0;
        we_q <= MemWrite;
        mem_addr <= {ALUResult[MIPS_SIZE-1:2], 2'b00};
        mem_wdata <= WriteData;
      end else if (state == WAIT && !mem_ack) cnt <= cnt + 1'b1;
      if (state == WAIT && mem_ack && !we_q) ReadData <= mem_rdata;
      else if (timeout) ReadData <= '0;
    end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed vector table, corner-case sequences and randomized
// transactions checked against a transaction-level model of the controller.
module tb_data_mem_ctrl;
  localparam int W = 32, TO = 16;
  logic CLK = 0, RST = 1, MemRead = 0, MemWrite = 0, mem_ack = 0;
  logic [W-1:0] ALUResult = 0, WriteData = 0, mem_rdata = 0;
  logic [W-1:0] ReadData, mem_addr, mem_wdata;
  logic Stall, Addr_Err, Bus_Err, mem_req, mem_we;
  int vectors = 0, miscompares = 0;
  logic [W-1:0] ma_m = 0, mw_m = 0, exp_rd = 0;

  typedef struct {
    logic [2:0]   in;
    logic [W-1:0] addr, wd, mrd;
    logic [4:0]   fl;
    logic [W-1:0] ma, mw, rdat;
  } vec_t;
  vec_t tbl[$];

  data_mem_ctrl #(.MIPS_SIZE(W), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .MemRead(MemRead), .MemWrite(MemWrite),
    .ALUResult(ALUResult), .WriteData(WriteData), .ReadData(ReadData),
    .Stall(Stall), .Addr_Err(Addr_Err), .Bus_Err(Bus_Err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [W-1:0] addr, input logic [W-1:0] wd,
                       input logic ack, input logic [W-1:0] mrd);
    @(negedge CLK);
    MemRead = rd; MemWrite = wr; ALUResult = addr; WriteData = wd; mem_ack = ack; mem_rdata = mrd;
    #2;
  endtask

  // fl = {Stall, mem_req, mem_we, Addr_Err, Bus_Err}
  task automatic expect_out(input logic [4:0] fl, input logic [W-1:0] ma, input logic [W-1:0] mw,
                            input logic [W-1:0] rdat);
    chk("Stall", Stall, fl[4]);
    chk("mem_req", mem_req, fl[3]);
    chk("mem_we", mem_we, fl[2]);
    chk("Addr_Err", Addr_Err, fl[1]);
    chk("Bus_Err", Bus_Err, fl[0]);
    chk("mem_addr", mem_addr, ma);
    chk("mem_wdata", mem_wdata, mw);
    chk("ReadData", ReadData, rdat);
  endtask

  // Requests are presented during reset to show nothing escapes while RST is low.
  task automatic do_reset(input logic [W-1:0] a);
    @(negedge CLK);
    RST = 0; MemRead = 1; MemWrite = a[2]; ALUResult = a; mem_ack = 1;
    #2;
    expect_out(5'b00000, 0, 0, 0);
    @(negedge CLK);
    RST = 1; MemRead = 0; MemWrite = 0; ALUResult = 0; mem_ack = 0;
    ma_m = 0; mw_m = 0; exp_rd = 0;
  endtask

  // One core access: d is the WAIT index carrying mem_ack; d >= TO means no ack (timeout).
  task automatic run_txn(input logic rd, input logic wr, input logic [W-1:0] addr, input logic [W-1:0] wd,
                         input int d);
    logic [W-1:0] data;
    int n;
    data = $urandom;
    drive(rd, wr, addr, wd, 1'($urandom_range(0, 1)), $urandom);
    if (!(rd || wr) || addr[1:0] != 2'b00) begin
      expect_out({3'b000, rd || wr, 1'b0}, ma_m, mw_m, exp_rd);
      return;
    end
    expect_out(5'b10000, ma_m, mw_m, exp_rd);
    ma_m = addr; mw_m = wd;
    n = d < TO ? d + 1 : TO;
    for (int k = 0; k < n; k++) begin
      drive(rd, wr, addr, wd, k == d, k == d ? data : W'($urandom));
      expect_out({2'b11, wr, 2'b00}, ma_m, mw_m, exp_rd);
    end
    if (d >= TO) exp_rd = 0;
    else if (!wr) exp_rd = data;
    drive(rd, wr, addr, wd, 1'($urandom_range(0, 1)), $urandom);
    expect_out({4'b0000, d >= TO}, ma_m, mw_m, exp_rd);
  endtask

  initial begin
    tbl.push_back(vec_t'{3'b100, 32'h10, 32'h0, 32'h0,        5'b10000, 32'h0,  32'h0,        32'h0});
    tbl.push_back(vec_t'{3'b100, 32'h10, 32'h0, 32'h0,        5'b11000, 32'h10, 32'h0,        32'h0});
    tbl.push_back(vec_t'{3'b101, 32'h10, 32'h0, 32'hCAFEF00D, 5'b11000, 32'h10, 32'h0,        32'h0});
    tbl.push_back(vec_t'{3'b100, 32'h10, 32'h0, 32'h0,        5'b00000, 32'h10, 32'h0,        32'hCAFEF00D});
    tbl.push_back(vec_t'{3'b000, 32'h0,  32'h0, 32'h0,        5'b00000, 32'h10, 32'h0,        32'hCAFEF00D});
    tbl.push_back(vec_t'{3'b010, 32'h20, 32'h12345678, 32'h0, 5'b10000, 32'h10, 32'h0,        32'hCAFEF00D});
    tbl.push_back(vec_t'{3'b011, 32'h20, 32'h12345678, 32'hDEADBEEF, 5'b11100, 32'h20, 32'h12345678, 32'hCAFEF00D});
    tbl.push_back(vec_t'{3'b010, 32'h20, 32'h12345678, 32'h0, 5'b00000, 32'h20, 32'h12345678, 32'hCAFEF00D});
    tbl.push_back(vec_t'{3'b000, 32'h0,  32'h0, 32'h0,        5'b00000, 32'h20, 32'h12345678, 32'hCAFEF00D});
    tbl.push_back(vec_t'{3'b101, 32'h13, 32'h0, 32'h11111111, 5'b00010, 32'h20, 32'h12345678, 32'hCAFEF00D});
    tbl.push_back(vec_t'{3'b000, 32'h0,  32'h0, 32'h0,        5'b00000, 32'h20, 32'h12345678, 32'hCAFEF00D});
    tbl.push_back(vec_t'{3'b110, 32'h40, 32'hA5A5A5A5, 32'h0, 5'b10000, 32'h20, 32'h12345678, 32'hCAFEF00D});
    tbl.push_back(vec_t'{3'b111, 32'h40, 32'hA5A5A5A5, 32'h77777777, 5'b11100, 32'h40, 32'hA5A5A5A5, 32'hCAFEF00D});
    tbl.push_back(vec_t'{3'b110, 32'h40, 32'hA5A5A5A5, 32'h0, 5'b00000, 32'h40, 32'hA5A5A5A5, 32'hCAFEF00D});
    tbl.push_back(vec_t'{3'b000, 32'h0,  32'h0, 32'h0,        5'b00000, 32'h40, 32'hA5A5A5A5, 32'hCAFEF00D});

    do_reset(32'h10);
    do_reset(32'h13);
    foreach (tbl[i]) begin
      drive(tbl[i].in[2], tbl[i].in[1], tbl[i].addr, tbl[i].wd, tbl[i].in[0], tbl[i].mrd);
      expect_out(tbl[i].fl, tbl[i].ma, tbl[i].mw, tbl[i].rdat);
    end
    ma_m = 32'h40; mw_m = 32'hA5A5A5A5; exp_rd = 32'hCAFEF00D;

    run_txn(1, 0, 32'h100, 0, TO);
    run_txn(1, 0, 32'h104, 0, TO - 1);
    run_txn(1, 1, 32'h108, 32'h0BADC0DE, TO - 1);

    for (int t = 0; t < 60; t++) begin
      int op;
      logic [W-1:0] a;
      op = $urandom_range(0, 4);
      a = $urandom & ~32'h3;
      case (op)
        0: run_txn(0, 0, a, $urandom, 0);
        1: run_txn(1, 0, a, $urandom, $urandom_range(0, TO + 1));
        2: run_txn(0, 1, a, $urandom, $urandom_range(0, TO - 1));
        3: run_txn(1, 1, a, $urandom, $urandom_range(0, TO - 1));
        default: run_txn(1'($urandom_range(0, 1)), 1, a | W'($urandom_range(1, 3)), $urandom, 0);
      endcase
    end

    do_reset(32'h0);
    drive(1, 0, 32'h80, 0, 0, 0);
    expect_out(5'b10000, 0, 0, 0);
    repeat (2) begin
      drive(1, 0, 32'h80, 0, 0, 0);
      expect_out(5'b11000, 32'h80, 0, 0);
    end
    drive(1, 0, 32'h80, 0, 0, 0);
    chk("mem_req WAIT3", mem_req, 1);
    RST = 0;
    #1;
    chk("mem_req async drop", mem_req, 0);
    chk("Stall async drop", Stall, 0);
    chk("mem_addr async clear", mem_addr, 0);
    @(negedge CLK);
    RST = 1; MemRead = 0;
    drive(0, 0, 0, 0, 0, 0);
    expect_out(5'b00000, 0, 0, 0);
    ma_m = 0; mw_m = 0; exp_rd = 0;
    run_txn(1, 0, 32'h84, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 The block SHALL have the parameter MIPS_SIZE, default 32, giving the data and address width.
REQ-002 The block SHALL have the parameter TIMEOUT, default 16, giving the maximum number of WAIT cycles allowed for mem_ack.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset; the ports are listed below.
REQ-004 CLK  input  1  clock; all state updates on the rising edge.
REQ-005 RST  input  1  reset, asynchronous, active-low.
REQ-006 MemRead  input  1  load request from the core.
REQ-007 MemWrite  input  1  store request from the core.
REQ-008 ALUResult  input  MIPS_SIZE  byte address of the access.
REQ-009 WriteData  input  MIPS_SIZE  store data.
REQ-010 ReadData  output  MIPS_SIZE  load data returned to the core's result mux.
REQ-011 Stall  output  1  when high, the core holds PC and suppresses the register write.
REQ-012 Addr_Err  output  1  one-cycle pulse marking a misaligned access.
REQ-013 Bus_Err  output  1  one-cycle pulse marking a bus timeout.
REQ-014 mem_req, mem_we  output  1 each  memory bus request and write strobe.
REQ-015 mem_addr, mem_wdata  output  MIPS_SIZE each  memory bus address and write data.
REQ-016 mem_rdata  input  MIPS_SIZE  memory bus read data.
REQ-017 mem_ack  input  1  memory bus acknowledge.

Function
REQ-018 The FSM SHALL have exactly three states, IDLE, WAIT and DONE, and SHALL reset to IDLE.
REQ-019 The access SHALL be valid when MemRead or MemWrite is high; when both are high, the access SHALL be a write.
REQ-020 In IDLE, a valid access with ALUResult[1:0]==0 SHALL latch address, data and write flag, then go to WAIT on the next edge.
REQ-021 In IDLE, Stall SHALL be combinationally high while an aligned valid access is present.
REQ-022 In IDLE, a valid access with ALUResult[1:0]!=0 SHALL issue no bus request, SHALL pulse Addr_Err high for that cycle, and SHALL keep Stall low.
REQ-023 In WAIT, mem_req SHALL be high, and mem_addr, mem_we and mem_wdata SHALL hold the latched values.
REQ-024 In WAIT, Stall SHALL be high.
REQ-025 In WAIT, when mem_ack is high, mem_rdata SHALL be registered into ReadData for reads, and the FSM SHALL go to DONE.
REQ-026 For writes, ReadData SHALL be unchanged.
REQ-027 A cycle counter SHALL clear on entry to WAIT and SHALL increment each WAIT cycle without mem_ack.
REQ-028 When the counter reaches TIMEOUT-1 without mem_ack, the block SHALL go to DONE, pulse Bus_Err in the DONE cycle, and load ReadData with 0.
REQ-029 When mem_ack arrives in the same cycle the timeout expires, the ack SHALL take priority and Bus_Err SHALL stay low.
REQ-030 DONE SHALL last exactly one cycle, with Stall low; the core commits during that cycle.
REQ-031 DONE SHALL always return to IDLE and SHALL never start a new access.
REQ-032 The minimum latency of an aligned access SHALL be 3 cycles (IDLE, WAIT with ack, DONE).
REQ-033 mem_ack outside WAIT SHALL be ignored.
REQ-034 mem_req SHALL be low in IDLE and DONE.
REQ-035 mem_addr SHALL always be word-aligned, with bits [1:0]==0.

Reset
REQ-036 While RST is low, the FSM SHALL be IDLE and the counter SHALL be 0.
REQ-037 While RST is low, ReadData, mem_addr and mem_wdata SHALL be 0.
REQ-038 While RST is low, mem_req, mem_we, Stall, Addr_Err and Bus_Err SHALL be 0.
REQ-039 A reset asserted during WAIT SHALL drop mem_req immediately, without waiting for a clock edge, and SHALL abandon the access.

Verification
REQ-040 Load 0x0000_0010, mem_ack on the 2nd WAIT cycle with mem_rdata 0xCAFE_F00D -> Stall high for 3 cycles, then ReadData 0xCAFE_F00D with Stall low for 1 cycle.
REQ-041 Store 0x1234_5678 to 0x0000_0020, immediate ack -> mem_we=1, mem_addr=0x20, mem_wdata=0x1234_5678 held until ack; DONE after 1 WAIT cycle.
REQ-042 Load 0x0000_0013 -> Addr_Err pulse, mem_req stays 0, Stall 0, ReadData unchanged.
REQ-043 Load with no ack, TIMEOUT=16 -> 16 WAIT cycles, then Bus_Err pulse, ReadData 0, return to IDLE.
REQ-044 mem_ack arriving on the final timeout cycle -> data is accepted and Bus_Err stays 0.
REQ-045 RST driven low during the 3rd WAIT cycle -> mem_req falls without a clock edge; after release, the FSM is IDLE and all outputs are 0.
